rf_write_arbiter: RTL and testbench

- Shares the single write port of the 32x64 register file between two writeback requesters: req0 (ALU writeback) and req1 (load writeback).
- Arbitrates round-robin and drives the register-file write port from registered outputs.
- Contains a clear sequencer that sweeps zeros into registers 1..DEPTH-1 on command, for context flush.

---
 rtl/rf_write_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single write port of the register file between two
// writeback requesters (req0 = ALU, req1 = load) and runs a clear sequencer that
// sweeps zeros into registers 1..DEPTH-1 for a context flush.
//
// Optional build macro: RF_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin arbitration between req0 and req1
//   defined             : fixed priority, req0 always wins; no round-robin pointer
//
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   reqN_valid / reqN_ready  valid/ready handshake per requester (ready is combinational)
//   reqN_addr/data/ppp       destination register, write data, selective-write mode
//   clr_start                one-cycle pulse, starts a clear sweep
//   clr_busy                 sweep in progress
//   clr_done                 one-cycle pulse presented with the final sweep write
//   rf_write_enb, rf_addr_wr, rf_data_in, rf_pppsel
//                            registered register-file write port
//   grant_id                 requester behind the current rf_* write
//   err_ppp                  sticky: an illegal ppp code (101..111) was accepted
module rf_write_arbiter #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned DATAWIDTH = 64,
    parameter int unsigned ADDRWIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [0:ADDRWIDTH-1] req0_addr,
    input  logic [0:DATAWIDTH-1] req0_data,
    input  logic [0:2]           req0_ppp,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [0:ADDRWIDTH-1] req1_addr,
    input  logic [0:DATAWIDTH-1] req1_data,
    input  logic [0:2]           req1_ppp,

    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,

    output logic                 rf_write_enb,
    output logic [0:ADDRWIDTH-1] rf_addr_wr,
    output logic [0:DATAWIDTH-1] rf_data_in,
    output logic [0:2]           rf_pppsel,
    output logic                 grant_id,
    output logic                 err_ppp
);

    // One extra bit so the DEPTH-1 terminal compare is exact.
    localparam int unsigned CntW = ADDRWIDTH + 1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        clr_cnt_q, clr_cnt_d;
    logic                   clr_done_q, clr_done_d;
    logic                   wr_enb_q, wr_enb_d;
    logic [0:ADDRWIDTH-1]   wr_addr_q, wr_addr_d;
    logic [0:DATAWIDTH-1]   wr_data_q, wr_data_d;
    logic [0:2]             wr_ppp_q, wr_ppp_d;
    logic                   grant_q, grant_d;
    logic                   err_q, err_d;

    logic                   arb_open;
    logic                   gnt0, gnt1;
    logic [0:ADDRWIDTH-1]   sel_addr;
    logic [0:DATAWIDTH-1]   sel_data;
    logic [0:2]             sel_ppp;
    logic                   sel_legal;

    // The clr_done cycle is still owned by the sequencer, so requesters regain ready
    // only on the following cycle; clr_start always beats a pending request.
    assign arb_open = (state_q == StIdle) && !clr_done_q && !clr_start;

`ifdef RF_ARB_FIXED_PRIO_EN
    assign gnt0 = arb_open && req0_valid;
    assign gnt1 = arb_open && req1_valid && !req0_valid;
`else
    // rr_ptr_q=1 means req1 is preferred on contention (req0 was granted last).
    logic rr_ptr_q, rr_ptr_d;

    assign gnt0 = arb_open && req0_valid && (!req1_valid || !rr_ptr_q);
    assign gnt1 = arb_open && req1_valid && (!req0_valid || rr_ptr_q);
`endif

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign sel_addr  = gnt1 ? req1_addr : req0_addr;
    assign sel_data  = gnt1 ? req1_data : req0_data;
    assign sel_ppp   = gnt1 ? req1_ppp  : req0_ppp;
    assign sel_legal = (sel_ppp <= 3'd4);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        wr_enb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_ppp_d   = wr_ppp_q;
        grant_d    = grant_q;
        err_d      = err_q;
`ifndef RF_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (clr_start && !clr_done_q) begin
                    state_d = StClear;
                end else if (gnt0 || gnt1) begin
                    // Writes to r0 and illegal modes complete the handshake but are dropped.
                    wr_enb_d  = (sel_addr != '0) && sel_legal;
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                    wr_ppp_d  = sel_ppp;
                    grant_d   = gnt1;
                    err_d     = err_q | !sel_legal;
`ifndef RF_ARB_FIXED_PRIO_EN
                    rr_ptr_d  = gnt0;
`endif
                end
            end
            StClear: begin
                wr_enb_d  = 1'b1;
                wr_addr_d = clr_cnt_q[ADDRWIDTH-1:0];
                wr_data_d = '0;
                wr_ppp_d  = '0;
                if (clr_cnt_q == CntW'(DEPTH - 1)) begin
                    clr_cnt_d  = CntW'(1);
                    clr_done_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    clr_cnt_d = clr_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            clr_cnt_q  <= CntW'(1);
            clr_done_q <= 1'b0;
            wr_enb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_ppp_q   <= '0;
            grant_q    <= 1'b0;
            err_q      <= 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            wr_enb_q   <= wr_enb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_ppp_q   <= wr_ppp_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
`ifndef RF_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign clr_busy     = (state_q == StClear);
    assign clr_done     = clr_done_q;
    assign rf_write_enb = wr_enb_q;
    assign rf_addr_wr   = wr_addr_q;
    assign rf_data_in   = wr_data_q;
    assign rf_pppsel    = wr_ppp_q;
    assign grant_id     = grant_q;
    assign err_ppp      = err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a directed vector table, hand-written
// clear-sweep and reset-mid-sweep sequences, and randomized traffic checked against
// a transaction-level reference model (preferred requester + queue of pending sweep writes).
module tb_rf_write_arbiter;

    localparam int DEPTH = 32;
    localparam int DW    = 64;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready;
    logic [0:AW-1] req0_addr;
    logic [0:DW-1] req0_data;
    logic [0:2]    req0_ppp;
    logic          req1_valid, req1_ready;
    logic [0:AW-1] req1_addr;
    logic [0:DW-1] req1_data;
    logic [0:2]    req1_ppp;
    logic          clr_start, clr_busy, clr_done;
    logic          rf_write_enb;
    logic [0:AW-1] rf_addr_wr;
    logic [0:DW-1] rf_data_in;
    logic [0:2]    rf_pppsel;
    logic          grant_id, err_ppp;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(DEPTH), .DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ppp(req0_ppp),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ppp(req1_ppp),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .rf_write_enb(rf_write_enb), .rf_addr_wr(rf_addr_wr), .rf_data_in(rf_data_in),
        .rf_pppsel(rf_pppsel), .grant_id(grant_id), .err_ppp(err_ppp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_pref;      // requester preferred on contention
    int          m_clr[$];    // sweep addresses still to be written
    bit          e_enb, e_done, e_err, e_grant;
    int          e_addr, e_ppp;
    logic [63:0] e_data;

    function automatic void model_reset();
        m_pref = 0; m_clr.delete();
        e_enb = 0; e_done = 0; e_err = 0; e_grant = 0;
        e_addr = 0; e_ppp = 0; e_data = '0;
    endfunction

    function automatic void model_ready(output bit g0, output bit g1);
        bit avail = (m_clr.size() == 0) && !e_done && !clr_start;
`ifdef RF_ARB_FIXED_PRIO_EN
        g0 = avail && req0_valid;
`else
        g0 = avail && req0_valid && (!req1_valid || m_pref == 0);
`endif
        g1 = avail && req1_valid && !g0;
    endfunction

    function automatic void model_update(input bit g0, input bit g1);
        bit nd = 0;
        int a, p;
        e_enb = 0;
        if (m_clr.size() != 0) begin
            a = m_clr.pop_front();
            e_enb = 1; e_addr = a; e_data = '0; e_ppp = 0;
            if (m_clr.size() == 0) nd = 1;
        end else if (clr_start && !e_done) begin
            for (int k = 1; k < DEPTH; k++) m_clr.push_back(k);
        end else if (g0 || g1) begin
            a = g1 ? int'(req1_addr) : int'(req0_addr);
            p = g1 ? int'(req1_ppp) : int'(req0_ppp);
            e_grant = g1;
            if (a != 0 && p <= 4) begin
                e_enb = 1; e_addr = a; e_ppp = p;
                e_data = g1 ? req1_data : req0_data;
            end
            if (p > 4) e_err = 1;
            m_pref = g0;
        end
        e_done = nd;
    endfunction

    // Observations captured at the negedge of the last tick.
    bit o_r0, o_r1, o_enb, o_done;
    int o_addr;

    // Inputs are already driven (posedge+1); compare at negedge, advance model, return at posedge+1.
    task automatic tick();
        bit x0, x1;
        @(negedge clk);
        model_ready(x0, x1);
        chk("req0_ready", req0_ready, x0);
        chk("req1_ready", req1_ready, x1);
        chk("rf_write_enb", rf_write_enb, e_enb);
        chk("clr_busy", clr_busy, m_clr.size() != 0);
        chk("clr_done", clr_done, e_done);
        chk("err_ppp", err_ppp, e_err);
        if (e_enb) begin
            chk("rf_addr_wr", rf_addr_wr, e_addr);
            chk("rf_data_in", rf_data_in, e_data);
            chk("rf_pppsel", rf_pppsel, e_ppp);
            chk("grant_id", grant_id, e_grant);
        end
        o_r0 = req0_ready; o_r1 = req1_ready; o_enb = rf_write_enb;
        o_done = clr_done; o_addr = int'(rf_addr_wr);
        model_update(x0, x1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enb"}, rf_write_enb, 0);
        chk({tag, "_addr"}, rf_addr_wr, 0);
        chk({tag, "_data"}, rf_data_in, 0);
        chk({tag, "_ppp"}, rf_pppsel, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_busy"}, clr_busy, 0);
        chk({tag, "_done"}, clr_done, 0);
        chk({tag, "_err"}, err_ppp, 0);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; clr_start = 0;
    endtask

    typedef struct {
        bit v0; int a0; logic [63:0] d0; int p0;
        bit v1; int a1; logic [63:0] d1; int p1;
        bit xr0; bit xr1; bit xenb; int xaddr; logic [63:0] xdata; int xppp; bit xgrant;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit got, seen_done, hit10;
        int wr, nexp, dones;

        // Contention rows 0..3, then single transfer, drops, legal 'o' and 'e' modes.
`ifdef RF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            tbl[i] = '{1, 3, 64'hA0A0, 0, 1, 7, 64'hB1B1, 1, 1, 0, 1, 3, 64'hA0A0, 0, 0};
`else
        for (int i = 0; i < 4; i++)
            tbl[i] = (i % 2 == 0)
                ? '{1, 3, 64'hA0A0, 0, 1, 7, 64'hB1B1, 1, 1, 0, 1, 3, 64'hA0A0, 0, 0}
                : '{1, 3, 64'hA0A0, 0, 1, 7, 64'hB1B1, 1, 0, 1, 1, 7, 64'hB1B1, 1, 1};
`endif
        tbl[4] = '{1, 5, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0, 1, 0, 1, 5, 64'h0123456789ABCDEF, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 1, 0, 64'h55, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 9, 64'h66, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{1, 4, 64'h44, 4, 0, 0, 0, 0, 1, 0, 1, 4, 64'h44, 4, 0};
        tbl[9] = '{0, 0, 0, 0, 1, 31, 64'hFEED, 3, 0, 1, 1, 31, 64'hFEED, 3, 1};

        reset = 0;
        idle_inputs();
        req0_addr = '0; req0_data = '0; req0_ppp = '0;
        req1_addr = '0; req1_data = '0; req1_ppp = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) reset = 1;
        @(posedge clk);
        #1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 10; i++) begin
            req0_valid = tbl[i].v0; req0_addr = AW'(tbl[i].a0);
            req0_data = tbl[i].d0; req0_ppp = 3'(tbl[i].p0);
            req1_valid = tbl[i].v1; req1_addr = AW'(tbl[i].a1);
            req1_data = tbl[i].d1; req1_ppp = 3'(tbl[i].p1);
            tick();
            chk($sformatf("tbl%0d_r0", i), o_r0, tbl[i].xr0);
            chk($sformatf("tbl%0d_r1", i), o_r1, tbl[i].xr1);
            chk($sformatf("tbl%0d_enb", i), rf_write_enb, tbl[i].xenb);
            if (tbl[i].xenb) begin
                chk($sformatf("tbl%0d_addr", i), rf_addr_wr, tbl[i].xaddr);
                chk($sformatf("tbl%0d_data", i), rf_data_in, tbl[i].xdata);
                chk($sformatf("tbl%0d_ppp", i), rf_pppsel, tbl[i].xppp);
                chk($sformatf("tbl%0d_grant", i), grant_id, tbl[i].xgrant);
            end
        end
        idle_inputs();
        repeat (10) tick();
        chk("err_sticky_10cyc", err_ppp, 1);

        // ---------------- clear sweep with req0 pending ----------------
        req0_valid = 1; req0_addr = 12; req0_data = 64'hC0FFEE; req0_ppp = 0;
        clr_start = 1;
        tick();
        chk("clr_start_blocks_r0", o_r0, 0);
        clr_start = 0;
        wr = 0; nexp = 1; dones = 0; got = 0; seen_done = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (seen_done) begin
                chk("r0_after_done", o_r0, 1);
                got = 1;
            end else begin
                if (o_enb) begin
                    chk("sweep_addr", o_addr, nexp);
                    nexp++; wr++;
                end
                if (o_done) begin
                    dones++; seen_done = 1;
                    chk("done_after_write31", wr, 31);
                end else begin
                    chk("sweep_r0_blocked", o_r0, 0);
                end
            end
        end
        chk("sweep_writes", wr, 31);
        chk("sweep_done_once", dones, 1);
        chk("sweep_finished_in_budget", got, 1);
        idle_inputs();
        tick();
        chk("req0_written_after_sweep", o_enb && o_addr == 12, 1);

        // ---------------- reset mid-sweep ----------------
        clr_start = 1;
        tick();
        clr_start = 0;
        hit10 = 0;
        for (int c = 0; c < 40 && !hit10; c++) begin
            tick();
            if (o_enb && o_addr == 9) hit10 = 1;
        end
        chk("reached_write10", hit10, 1);
        chk("write10_presented", rf_addr_wr, 10);
        reset = 0;
        #1;
        check_all_zero("midsweep_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1;
        @(posedge clk);
        #1;
        repeat (5) tick();
        chk("no_done_after_reset", o_done, 0);
        clr_start = 1;
        tick();
        clr_start = 0;
        got = 0;
        for (int c = 0; c < 4 && !got; c++) begin
            tick();
            if (o_enb) begin
                chk("restart_first_addr", o_addr, 1);
                got = 1;
            end
        end
        chk("restart_write_seen", got, 1);
        repeat (34) tick();

        // ---------------- randomized traffic ----------------
        idle_inputs();
        o_r0 = 0; o_r1 = 0;
        for (int c = 0; c < 500; c++) begin
            if (!(req0_valid && !o_r0)) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_addr  = AW'($urandom_range(0, 31));
                req0_data  = {$urandom, $urandom};
                req0_ppp   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                                         : 3'($urandom_range(0, 4));
            end
            if (!(req1_valid && !o_r1)) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_addr  = AW'($urandom_range(0, 31));
                req1_data  = {$urandom, $urandom};
                req1_ppp   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                                         : 3'($urandom_range(0, 4));
            end
            clr_start = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle_inputs();
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
